// File: rtl/uart_verici_hakem_if.sv
// Byte bus between the producers, the arbiter and the UART transmitter.
// Requester r drives bit r of istek_gecerli_i / istek_son_i and bits
// [8r+7:8r] of istek_veri_i. The arbiter uses the slave modport. The
// producer/transmitter side uses the master modport.
interface uart_verici_hakem_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   istek_gecerli_i;
  logic [8*NUM_REQ-1:0] istek_veri_i;
  logic [NUM_REQ-1:0]   istek_son_i;
  logic [NUM_REQ-1:0]   istek_kabul_o;
  logic                 verici_gecerli_o;
  logic [7:0]           verici_veri_o;
  logic                 verici_consume_i;

  modport slave (
    input  istek_gecerli_i,
    input  istek_veri_i,
    input  istek_son_i,
    input  verici_consume_i,
    output istek_kabul_o,
    output verici_gecerli_o,
    output verici_veri_o
  );

  modport master (
    output istek_gecerli_i,
    output istek_veri_i,
    output istek_son_i,
    output verici_consume_i,
    input  istek_kabul_o,
    input  verici_gecerli_o,
    input  verici_veri_o
  );
endinterface

// File: rtl/uart_verici_hakem.sv
// Round-robin, packet-locked arbiter that shares one UART transmitter
// between NUM_REQ byte producers. A granted requester keeps the
// transmitter until one of its bytes flagged "son" is consumed.
//
// Optional feature: define UART_VERICI_HAKEM_ZAMAN_ASIMI_EN to evict an
// owner that has kept valid low for ZAMAN_ASIMI cycles. Without the macro
// no counter is built and zaman_asimi_o is tied low.

// Per-requester lane: masks the requester's byte onto the shared bus when
// it is the locked owner and forms its consume pulse.
module uart_verici_hakem_serit #(
  parameter int ID_W = 2,
  parameter int IDX  = 0
) (
  input  logic [ID_W-1:0] sahip,
  input  logic            kilitli,
  input  logic            gecerli,
  input  logic [7:0]      veri,
  input  logic            son,
  input  logic            consume,
  output logic            gecerli_m,
  output logic [7:0]      veri_m,
  output logic            kabul,
  output logic            son_kabul
);
  logic secili;

  assign secili    = kilitli && (sahip == ID_W'(IDX));
  assign gecerli_m = secili & gecerli;
  assign veri_m    = secili ? veri : 8'h00;
  // A consume while nothing is presented is ignored.
  assign kabul     = gecerli_m & consume;
  assign son_kabul = kabul & son;
endmodule

module uart_verici_hakem #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ZAMAN_ASIMI = 50000
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  uart_verici_hakem_if.slave  bus,
  output logic [ID_W-1:0]     sahip_o,
  output logic                kilitli_o,
  output logic                zaman_asimi_o
);

  // Reject configurations the owner index or timeout counter cannot hold.
  if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 ||
      ZAMAN_ASIMI < 2 || ZAMAN_ASIMI > 65535) begin : g_param_hata
    $error("uart_verici_hakem: illegal NUM_REQ/ID_W/ZAMAN_ASIMI");
  end

  typedef enum logic {BOSTA = 1'b0, SAHIPLI = 1'b1} durum_t;

  durum_t          durum_r, durum_d;
  logic [ID_W-1:0] sahip_r, sahip_d;
  logic [ID_W-1:0] son_sahip_r, son_sahip_d;
  logic [ID_W-1:0] secim;
  logic            kilitli;
  logic            sure_doldu;

  logic [NUM_REQ-1:0][7:0] veri_v;
  logic [NUM_REQ-1:0][7:0] veri_m;
  logic [NUM_REQ-1:0]      gecerli_m;
  logic [NUM_REQ-1:0]      kabul;
  logic [NUM_REQ-1:0]      son_kabul;
  logic                    sahip_gecerli;
  logic                    herhangi_kabul;
  logic                    son_geldi;

  assign veri_v  = bus.istek_veri_i;
  assign kilitli = (durum_r == SAHIPLI);

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_serit
    uart_verici_hakem_serit #(
      .ID_W (ID_W),
      .IDX  (r)
    ) u_serit (
      .sahip     (sahip_r),
      .kilitli   (kilitli),
      .gecerli   (bus.istek_gecerli_i[r]),
      .veri      (veri_v[r]),
      .son       (bus.istek_son_i[r]),
      .consume   (bus.verici_consume_i),
      .gecerli_m (gecerli_m[r]),
      .veri_m    (veri_m[r]),
      .kabul     (kabul[r]),
      .son_kabul (son_kabul[r])
    );
  end

  // Only the owner lane is non-zero, so OR-merging selects its byte.
  always_comb begin
    bus.verici_veri_o = 8'h00;
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.verici_veri_o = bus.verici_veri_o | veri_m[r];
    end
  end

  assign sahip_gecerli        = |gecerli_m;
  assign bus.verici_gecerli_o = sahip_gecerli;
  assign bus.istek_kabul_o    = kabul;
  assign herhangi_kabul       = |kabul;
  assign son_geldi            = |son_kabul;

  // Round-robin pick: scan son_sahip_r+1, +2, ... wrapping. Iterating from
  // the farthest distance down lets the nearest valid requester win last.
  always_comb begin
    int hedef;
    secim = '0;
    hedef = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      hedef = int'(son_sahip_r) + i;
      if (hedef >= NUM_REQ) hedef = hedef - NUM_REQ;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (bus.istek_gecerli_i[r] && (hedef == r)) secim = ID_W'(r);
      end
    end
  end

`ifdef UART_VERICI_HAKEM_ZAMAN_ASIMI_EN
  localparam logic [15:0] SAYAC_SON = 16'(ZAMAN_ASIMI - 1);

  logic [15:0] sayac_r;
  logic        zaman_r;

  // Eviction fires on the idle cycle that finds the counter already at its
  // last value, i.e. after ZAMAN_ASIMI consecutive idle owner cycles.
  assign sure_doldu = kilitli && !bus.istek_gecerli_i[sahip_r] &&
                      (sayac_r == SAYAC_SON);

  // Idle-owner counter: held at 0 outside SAHIPLI, cleared by every kabul.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sayac_r <= '0;
    end else if (!kilitli || herhangi_kabul || sure_doldu) begin
      sayac_r <= '0;
    end else if (!bus.istek_gecerli_i[sahip_r]) begin
      sayac_r <= sayac_r + 16'd1;
    end
  end

  // One-cycle eviction pulse, visible in the first BOSTA cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) zaman_r <= 1'b0;
    else         zaman_r <= sure_doldu;
  end

  assign zaman_asimi_o = zaman_r;
`else
  assign sure_doldu    = 1'b0;
  assign zaman_asimi_o = 1'b0;
`endif

  // State, owner and last-owner registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_r     <= BOSTA;
      sahip_r     <= '0;
      son_sahip_r <= ID_W'(NUM_REQ - 1);
    end else begin
      durum_r     <= durum_d;
      sahip_r     <= sahip_d;
      son_sahip_r <= son_sahip_d;
    end
  end

  // Next state: grant from BOSTA, release on a consumed "son" byte or
  // on timeout. Releasing records the owner so it gets lowest priority.
  always_comb begin
    durum_d     = durum_r;
    sahip_d     = sahip_r;
    son_sahip_d = son_sahip_r;
    case (durum_r)
      BOSTA: begin
        if (|bus.istek_gecerli_i) begin
          sahip_d = secim;
          durum_d = SAHIPLI;
        end
      end
      SAHIPLI: begin
        if (son_geldi || sure_doldu) begin
          son_sahip_d = sahip_r;
          durum_d     = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  assign sahip_o   = sahip_r;
  assign kilitli_o = kilitli;

endmodule

// File: tb/tb_uart_verici_hakem.sv
// Directed bench for uart_verici_hakem: reset values, arbitration latency,
// round-robin order, packet locking, owner stall and asynchronous reset.
module tb_uart_verici_hakem;
  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int ZAMAN_ASIMI = 8;

  logic            clk_i  = 1'b0;
  logic            rstn_i = 1'b0;
  logic [ID_W-1:0] sahip_o;
  logic            kilitli_o;
  logic            zaman_asimi_o;
  int              checks = 0;
  int              errors = 0;

  uart_verici_hakem_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_verici_hakem #(
    .NUM_REQ     (NUM_REQ),
    .ID_W        (ID_W),
    .ZAMAN_ASIMI (ZAMAN_ASIMI)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .bus           (bus),
    .sahip_o       (sahip_o),
    .kilitli_o     (kilitli_o),
    .zaman_asimi_o (zaman_asimi_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rq(input int r, input logic g, input logic [7:0] v, input logic s);
    bus.istek_gecerli_i[r]     = g;
    bus.istek_veri_i[8*r +: 8] = v;
    bus.istek_son_i[r]         = s;
  endtask

  task automatic chk_bos(input string tag);
    chk({tag, "_kabul"},   32'(bus.istek_kabul_o),    32'h0);
    chk({tag, "_gecerli"}, 32'(bus.verici_gecerli_o), 32'h0);
    chk({tag, "_veri"},    32'(bus.verici_veri_o),    32'h0);
    chk({tag, "_sahip"},   32'(sahip_o),              32'h0);
    chk({tag, "_kilitli"}, 32'(kilitli_o),            32'h0);
    chk({tag, "_zaman"},   32'(zaman_asimi_o),        32'h0);
  endtask

  initial begin
    bus.istek_gecerli_i  = '0;
    bus.istek_veri_i     = '0;
    bus.istek_son_i      = '0;
    bus.verici_consume_i = 1'b0;
    #1;
    chk_bos("reset");

    // T1: single-byte packet from req1, 1-cycle grant latency.
    @(negedge clk_i);
    rstn_i = 1'b1;
    rq(1, 1'b1, 8'h41, 1'b1);
    #1;
    chk("t1_pre_gecerli", 32'(bus.verici_gecerli_o), 32'h0);
    step();
    chk("t1_gecerli", 32'(bus.verici_gecerli_o), 32'h1);
    chk("t1_veri",    32'(bus.verici_veri_o),    32'h41);
    chk("t1_sahip",   32'(sahip_o),              32'h1);
    chk("t1_kilitli", 32'(kilitli_o),            32'h1);
    bus.verici_consume_i = 1'b1;
    #1;
    chk("t1_kabul", 32'(bus.istek_kabul_o), 32'b0010);
    step();
    bus.verici_consume_i = 1'b0;
    rq(1, 1'b0, 8'h00, 1'b0);
    #1;
    chk("t1_kabul_bitti", 32'(bus.istek_kabul_o), 32'h0);
    chk("t1_bosta",       32'(kilitli_o),         32'h0);

    // T2: req0 and req2 from reset; round-robin gives 0, 2, 0.
    rstn_i = 1'b0;
    rq(0, 1'b1, 8'hA0, 1'b1);
    rq(2, 1'b1, 8'hC2, 1'b1);
    @(negedge clk_i);
    rstn_i = 1'b1;
    step();
    chk("t2_sahip0", 32'(sahip_o),              32'h0);
    chk("t2_veri0",  32'(bus.verici_veri_o),    32'hA0);
    bus.verici_consume_i = 1'b1;
    #1;
    chk("t2_kabul0", 32'(bus.istek_kabul_o), 32'b0001);
    step();
    bus.verici_consume_i = 1'b0;
    rq(0, 1'b1, 8'hA1, 1'b1);
    #1;
    chk("t2_bosta", 32'(kilitli_o), 32'h0);
    step();
    chk("t2_sahip2", 32'(sahip_o),           32'h2);
    chk("t2_veri2",  32'(bus.verici_veri_o), 32'hC2);
    bus.verici_consume_i = 1'b1;
    #1;
    chk("t2_kabul2", 32'(bus.istek_kabul_o), 32'b0100);
    step();
    bus.verici_consume_i = 1'b0;
    rq(2, 1'b0, 8'h00, 1'b0);
    step();
    chk("t2_sahip0b", 32'(sahip_o),           32'h0);
    chk("t2_veri0b",  32'(bus.verici_veri_o), 32'hA1);
    bus.verici_consume_i = 1'b1;
    #1;
    chk("t2_kabul0b", 32'(bus.istek_kabul_o), 32'b0001);
    step();
    bus.verici_consume_i = 1'b0;
    rq(0, 1'b0, 8'h00, 1'b0);

    // T3: req3 sends 0x10,0x11,0x12 back to back while req0 keeps asking.
    rq(0, 1'b1, 8'hB0, 1'b1);
    rq(3, 1'b1, 8'h10, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("t3_sahip",   32'(sahip_o),              32'h3);
      chk("t3_gecerli", 32'(bus.verici_gecerli_o), 32'h1);
      chk("t3_veri",    32'(bus.verici_veri_o),    32'h10 + 32'(k));
      bus.verici_consume_i = 1'b1;
      #1;
      chk("t3_kabul", 32'(bus.istek_kabul_o), 32'b1000);
      step();
      bus.verici_consume_i = 1'b0;
      if (k == 0) rq(3, 1'b1, 8'h11, 1'b0);
      if (k == 1) rq(3, 1'b1, 8'h12, 1'b1);
      if (k == 2) rq(3, 1'b0, 8'h00, 1'b0);
      #1;
    end
    chk("t3_bosta", 32'(kilitli_o), 32'h0);
    step();
    chk("t3_sahip0", 32'(sahip_o),           32'h0);
    chk("t3_veri0",  32'(bus.verici_veri_o), 32'hB0);
    bus.verici_consume_i = 1'b1;
    #1;
    chk("t3_kabul0", 32'(bus.istek_kabul_o), 32'b0001);
    step();
    bus.verici_consume_i = 1'b0;
    rq(0, 1'b0, 8'h00, 1'b0);

    // T4: req1 owns, then goes idle with req2 waiting.
    rq(1, 1'b1, 8'h55, 1'b0);
    step();
    chk("t4_sahip1", 32'(sahip_o), 32'h1);
    bus.verici_consume_i = 1'b1;
    #1;
    chk("t4_kabul1", 32'(bus.istek_kabul_o), 32'b0010);
    step();
    bus.verici_consume_i = 1'b0;
    rq(1, 1'b0, 8'h00, 1'b0);
    rq(2, 1'b1, 8'hC5, 1'b1);
`ifdef UART_VERICI_HAKEM_ZAMAN_ASIMI_EN
    for (int k = 0; k < ZAMAN_ASIMI; k++) begin
      chk("t4z_kilitli", 32'(kilitli_o),     32'h1);
      chk("t4z_zaman",   32'(zaman_asimi_o), 32'h0);
      step();
    end
    chk("t4z_tahliye", 32'(kilitli_o),     32'h0);
    chk("t4z_darbe",   32'(zaman_asimi_o), 32'h1);
    step();
    chk("t4z_darbe_bitti", 32'(zaman_asimi_o), 32'h0);
    chk("t4z_sahip2",      32'(sahip_o),       32'h2);
`else
    bus.verici_consume_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("t4_kabul_yok", 32'(bus.istek_kabul_o),    32'h0);
      chk("t4_gecerli",   32'(bus.verici_gecerli_o), 32'h0);
      chk("t4_kilitli",   32'(kilitli_o),            32'h1);
      chk("t4_sahip",     32'(sahip_o),              32'h1);
      chk("t4_zaman",     32'(zaman_asimi_o),        32'h0);
      step();
    end
    bus.verici_consume_i = 1'b0;
    rq(1, 1'b1, 8'h56, 1'b1);
    #1;
    chk("t4_devam_gecerli", 32'(bus.verici_gecerli_o), 32'h1);
    chk("t4_devam_veri",    32'(bus.verici_veri_o),    32'h56);
    bus.verici_consume_i = 1'b1;
    #1;
    chk("t4_devam_kabul", 32'(bus.istek_kabul_o), 32'b0010);
    step();
    bus.verici_consume_i = 1'b0;
    rq(1, 1'b0, 8'h00, 1'b0);
    #1;
    chk("t4_bosta", 32'(kilitli_o), 32'h0);
    step();
    chk("t4_sahip2", 32'(sahip_o), 32'h2);
`endif
    chk("t4_veri2", 32'(bus.verici_veri_o), 32'hC5);
    bus.verici_consume_i = 1'b1;
    #1;
    chk("t4_kabul2", 32'(bus.istek_kabul_o), 32'b0100);
    step();
    bus.verici_consume_i = 1'b0;
    rq(2, 1'b0, 8'h00, 1'b0);

    // T5: asynchronous reset in the middle of a req3 packet.
    rq(3, 1'b1, 8'h31, 1'b0);
    rq(1, 1'b1, 8'h11, 1'b1);
    step();
    chk("t5_sahip3", 32'(sahip_o), 32'h3);
    bus.verici_consume_i = 1'b1;
    #1;
    chk("t5_kabul3", 32'(bus.istek_kabul_o), 32'b1000);
    step();
    rq(3, 1'b1, 8'h32, 1'b0);
    #1;
    chk("t5_kilitli_once", 32'(kilitli_o), 32'h1);
    rstn_i = 1'b0;
    #1;
    chk_bos("t5_async");
    bus.verici_consume_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    step();
    chk("t5_sahip1", 32'(sahip_o),           32'h1);
    chk("t5_veri1",  32'(bus.verici_veri_o), 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
